cu_microsequencer: RTL and testbench
====================================

Name: cu_microsequencer

Overview:
- Holds and advances the control address register (CAR) that indexes the microprogram control memory.
- Each cycle it reads the sequencing field of the current 24-bit control word, the IR opcode, the indirect-addressing bit and the memory wait line, and computes the next CAR.
- Also owns processor run/halt state and flags illegal opcodes.
- Sits between the IR/memory interface and the control memory inside the control unit.

Parameters:
- CAR_W, 8: CAR width.
- FETCH_ADDR, 8'h00: microprogram entry point (IF1).
- IND_ADDR, 8'h05: IND1 entry.
- HALT_WB_ADDR, 8'h17: HALT WB micro-address.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- control_word  input  24  current control memory output; bits [21:20] are the sequencing field.
- opcode  input  8  IR opcode field, stable from ID2 onward.
- ind_bit  input  1  IR indirect-addressing flag.
- mem_wait  input  1  memory not ready; freezes sequencing.
- resume  input  1  restart pulse while halted.
- car  output  CAR_W  control address register.
- halted  output  1  processor halted.
- instr_done  output  1  one-cycle pulse when an END step retires.
- illegal_op  output  1  one-cycle pulse on an unmapped opcode dispatch.

Behaviour:
- Reset (async, rst=1):
  - car=FETCH_ADDR, halted=0, instr_done=0, illegal_op=0.
  - Takes effect immediately, even mid-instruction or mid-stall.
- States: RUN, STALL, HALTED. Reset state is RUN.
- RUN, mem_wait=0: car updates every clk according to the sequencing field seq=control_word[21:20]:
  - 2'b10 INC: car <= car+1. Exception: car=8'h0D goes to 8'h0F (SUB WB is at 0x0F).
  - 2'b01 DISPATCH:
    - ind_bit=1: car <= IND_ADDR.
    - ind_bit=0: car <= map(opcode).
  - 2'b11 END:
    - Pulses instr_done the next cycle.
    - If car=HALT_WB_ADDR: car <= FETCH_ADDR and state goes to HALTED.
    - Otherwise: car <= FETCH_ADDR.
  - 2'b00 (including the all-zero default word): treated as END. Also pulses illegal_op.
  - Fixed exception: at car=8'h06 (IND2) the next address is always map(opcode), whatever seq says.
- Dispatch map (opcode -> EX address):
  - 01 -> 07 STORE
  - 02 -> 09 LOAD
  - 03 -> 0B ADD
  - 04 -> 0D SUB
  - 05 -> 12 JMPGEZ
  - 06 -> 14 JUMP
  - 07 -> 16 HALT
  - 08 -> 10 MPY
  - 0A -> 18 AND
  - 0B -> 1A OR
  - 0C -> 1C NOT
  - 0D -> 1E SHIFTR
  - 0E -> 20 SHIFTL
  - Any other opcode: car <= FETCH_ADDR and illegal_op pulses next cycle. No instr_done.
- STALL:
  - Entered from RUN when mem_wait=1 is sampled at a clk edge. car holds.
  - Returns to RUN on the first edge that samples mem_wait=0; that edge performs the normal next-address computation.
  - Net effect: each cycle with mem_wait=1 adds exactly one cycle. Zero extra latency when mem_wait stays low.
- HALTED:
  - car held at FETCH_ADDR, halted=1; mem_wait ignored.
  - resume=1 at an edge: halted=0, state goes to RUN. car stays FETCH_ADDR, so fetch starts the following cycle.
  - resume while not halted is ignored.
- Simultaneous events:
  - mem_wait=1 on an END or DISPATCH cycle: stall wins and the pulse is deferred.
  - rst beats everything.
- Wrap-around: INC from 8'hFF gives 8'h00 (modulo 2^CAR_W).
- All outputs are registered. instr_done and illegal_op are never high together and never high for two consecutive cycles from one event.

Test Plan:
- ADD, direct: reset, opcode=03, ind_bit=0, control words per the microprogram -> car sequence 00,01,02,03,04,0B,0C,00. instr_done pulses once, on the cycle car returns to 00.
- SUB with indirect: opcode=04, ind_bit=1 -> car sequence 00..04,05,06,0D,0F,00. 0x0E is never visited.
- HALT: opcode=07 -> car 00..04,16,17,00, then halted=1 and car frozen for 10 cycles. A resume pulse clears halted, and car=01 on the following edge.
- Stall: hold mem_wait=1 for 3 cycles while car=01 -> car stays 01 for 4 cycles, then goes to 02. Total instruction length grows by exactly 3.
- Illegal opcode: opcode=09 at FO -> car goes to 00, illegal_op high for one cycle, instr_done stays 0. A zero control word produces the same response.
- Async reset: assert rst mid-MPY (car=10) between clock edges -> car=00 and halted=0 immediately, with no outputs pulsing.

Source files
------------

// File: rtl/cu_microsequencer.sv
// Control-unit microsequencer: owns the control address register,
// run/stall/halt state, and the opcode dispatch map.
module cu_microsequencer #(
  parameter int unsigned CAR_W = 8,
  parameter logic [CAR_W-1:0] FETCH_ADDR = 8'h00,
  parameter logic [CAR_W-1:0] IND_ADDR = 8'h05,
  parameter logic [CAR_W-1:0] HALT_WB_ADDR = 8'h17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [23:0]      control_word,
  input  logic [7:0]       opcode,
  input  logic             ind_bit,
  input  logic             mem_wait,
  input  logic             resume,
  output logic [CAR_W-1:0] car,
  output logic             halted,
  output logic             instr_done,
  output logic             illegal_op
);

  localparam logic [1:0] S_RUN = 2'd0;
  localparam logic [1:0] S_STALL = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  localparam logic [1:0] SEQ_NONE = 2'b00;
  localparam logic [1:0] SEQ_DISP = 2'b01;
  localparam logic [1:0] SEQ_INC = 2'b10;
  localparam logic [1:0] SEQ_END = 2'b11;

  localparam logic [CAR_W-1:0] IND2_ADDR = CAR_W'(8'h06);
  localparam logic [CAR_W-1:0] SUB_EX = CAR_W'(8'h0D);
  localparam logic [CAR_W-1:0] SUB_WB = CAR_W'(8'h0F);

  logic [1:0]       st;
  logic [1:0]       st_n;
  logic [CAR_W-1:0] car_n;
  logic             done_n;
  logic             ill_n;
  logic [1:0]       seq;
  logic [CAR_W:0]   map_r;
  logic             unused_cw;

  assign seq = control_word[21:20];
  assign unused_cw = ^{control_word[23:22], control_word[19:0]};

  // Opcode -> EX micro-address; top bit flags a mapped opcode.
  function automatic logic [CAR_W:0] map_op(input logic [7:0] op);
    logic [CAR_W:0] r;
    r = {1'b1, FETCH_ADDR};
    case (op)
      8'h01: r[CAR_W-1:0] = CAR_W'(8'h07);
      8'h02: r[CAR_W-1:0] = CAR_W'(8'h09);
      8'h03: r[CAR_W-1:0] = CAR_W'(8'h0B);
      8'h04: r[CAR_W-1:0] = CAR_W'(8'h0D);
      8'h05: r[CAR_W-1:0] = CAR_W'(8'h12);
      8'h06: r[CAR_W-1:0] = CAR_W'(8'h14);
      8'h07: r[CAR_W-1:0] = CAR_W'(8'h16);
      8'h08: r[CAR_W-1:0] = CAR_W'(8'h10);
      8'h0A: r[CAR_W-1:0] = CAR_W'(8'h18);
      8'h0B: r[CAR_W-1:0] = CAR_W'(8'h1A);
      8'h0C: r[CAR_W-1:0] = CAR_W'(8'h1C);
      8'h0D: r[CAR_W-1:0] = CAR_W'(8'h1E);
      8'h0E: r[CAR_W-1:0] = CAR_W'(8'h20);
      default: r = {1'b0, FETCH_ADDR};
    endcase
    return r;
  endfunction

  assign map_r = map_op(opcode);

  // Next address, next state and pulse requests for this cycle.
  always_comb begin
    car_n = car;
    st_n = st;
    done_n = 1'b0;
    ill_n = 1'b0;
    case (st)
      S_RUN, S_STALL: begin
        if (mem_wait) begin
          st_n = S_STALL;
        end else begin
          st_n = S_RUN;
          if (car == IND2_ADDR) begin
            car_n = map_r[CAR_W-1:0];
            ill_n = ~map_r[CAR_W];
          end else begin
            case (seq)
              SEQ_INC: begin
                car_n = (car == SUB_EX) ? SUB_WB : car + 1'b1;
              end
              SEQ_DISP: begin
                if (ind_bit) begin
                  car_n = IND_ADDR;
                end else begin
                  car_n = map_r[CAR_W-1:0];
                  ill_n = ~map_r[CAR_W];
                end
              end
              SEQ_END: begin
                car_n = FETCH_ADDR;
                done_n = 1'b1;
                if (car == HALT_WB_ADDR) st_n = S_HALTED;
              end
              SEQ_NONE: begin
                car_n = FETCH_ADDR;
                ill_n = 1'b1;
                if (car == HALT_WB_ADDR) st_n = S_HALTED;
              end
              default: car_n = FETCH_ADDR;
            endcase
          end
        end
      end
      S_HALTED: begin
        car_n = FETCH_ADDR;
        if (resume) st_n = S_RUN;
      end
      default: begin
        car_n = FETCH_ADDR;
        st_n = S_RUN;
      end
    endcase
  end

  // Register CAR, state and all outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      car <= FETCH_ADDR;
      st <= S_RUN;
      halted <= 1'b0;
      instr_done <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      car <= car_n;
      st <= st_n;
      halted <= (st_n == S_HALTED);
      instr_done <= done_n;
      illegal_op <= ill_n;
    end
  end

endmodule

// File: tb/tb_cu_microsequencer.sv
// Directed bench for cu_microsequencer driving a small
// microprogram ROM indexed by car.
module tb_cu_microsequencer;

  logic        clk;
  logic        rst;
  logic [23:0] control_word;
  logic [7:0]  opcode;
  logic        ind_bit;
  logic        mem_wait;
  logic        resume;
  logic [7:0]  car;
  logic        halted;
  logic        instr_done;
  logic        illegal_op;
  logic        zero_word;

  int checks = 0;
  int errors = 0;

  cu_microsequencer dut (
    .clk(clk),
    .rst(rst),
    .control_word(control_word),
    .opcode(opcode),
    .ind_bit(ind_bit),
    .mem_wait(mem_wait),
    .resume(resume),
    .car(car),
    .halted(halted),
    .instr_done(instr_done),
    .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] rom(input logic [7:0] a);
    logic [1:0] s;
    case (a)
      8'h00, 8'h01, 8'h02, 8'h03: s = 2'b10;
      8'h04: s = 2'b01;
      8'h05, 8'h06: s = 2'b10;
      8'h07, 8'h09, 8'h0B, 8'h0D: s = 2'b10;
      8'h10, 8'h12, 8'h16: s = 2'b10;
      default: s = 2'b11;
    endcase
    return {2'b00, s, 20'h0};
  endfunction

  assign control_word = zero_word ? 24'h0 : rom(car);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #4;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if (car !== 8'h00) begin
      errors++;
      $display("FAIL reset_car got %0h exp 00", car);
    end
    checks++;
    if ({halted, instr_done, illegal_op} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b exp 000",
               {halted, instr_done, illegal_op});
    end
    step();
    rst = 1'b0;
    #4;
  endtask

  task automatic test_add();
    logic [7:0] ex [8] = '{8'h01, 8'h02, 8'h03, 8'h04,
                           8'h0B, 8'h0C, 8'h00, 8'h01};
    do_reset();
    opcode = 8'h03;
    ind_bit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (car !== ex[i] || instr_done !== (i == 6)) begin
        errors++;
        $display("FAIL add_step%0d got car %0h done %b exp %0h %b",
                 i, car, instr_done, ex[i], (i == 6));
      end
    end
  endtask

  task automatic test_sub_indirect();
    logic [7:0] ex [9] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                           8'h06, 8'h0D, 8'h0F, 8'h00};
    do_reset();
    opcode = 8'h04;
    ind_bit = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      checks++;
      if (car !== ex[i] || instr_done !== (i == 8)) begin
        errors++;
        $display("FAIL sub_step%0d got car %0h done %b exp %0h %b",
                 i, car, instr_done, ex[i], (i == 8));
      end
    end
    ind_bit = 1'b0;
  endtask

  task automatic test_halt();
    logic [7:0] ex [7] = '{8'h01, 8'h02, 8'h03, 8'h04,
                           8'h16, 8'h17, 8'h00};
    logic [7:0] ex2 [6] = '{8'h01, 8'h02, 8'h03, 8'h04,
                            8'h0B, 8'h0C};
    do_reset();
    opcode = 8'h07;
    for (int i = 0; i < 7; i++) begin
      step();
      checks++;
      if (car !== ex[i] || halted !== (i == 6)) begin
        errors++;
        $display("FAIL halt_step%0d got car %0h halted %b exp %0h %b",
                 i, car, halted, ex[i], (i == 6));
      end
    end
    checks++;
    if (instr_done !== 1'b1) begin
      errors++;
      $display("FAIL halt_done got %b exp 1", instr_done);
    end
    mem_wait = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (car !== 8'h00 || halted !== 1'b1 || instr_done !== 1'b0) begin
        errors++;
        $display("FAIL halt_hold%0d got car %0h halted %b done %b",
                 i, car, halted, instr_done);
      end
    end
    mem_wait = 1'b0;
    resume = 1'b1;
    step();
    resume = 1'b0;
    checks++;
    if (car !== 8'h00 || halted !== 1'b0) begin
      errors++;
      $display("FAIL resume got car %0h halted %b exp 00 0",
               car, halted);
    end
    opcode = 8'h03;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (car !== ex2[i]) begin
        errors++;
        $display("FAIL post_resume%0d got %0h exp %0h",
                 i, car, ex2[i]);
      end
    end
    resume = 1'b1;
    step();
    resume = 1'b0;
    checks++;
    if (car !== 8'h00 || halted !== 1'b0 || instr_done !== 1'b1) begin
      errors++;
      $display("FAIL resume_ignored got car %0h halted %b done %b",
               car, halted, instr_done);
    end
  endtask

  task automatic test_stall();
    int n = 0;
    do_reset();
    opcode = 8'h03;
    step();
    n++;
    mem_wait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n++;
      checks++;
      if (car !== 8'h01) begin
        errors++;
        $display("FAIL stall_hold%0d got %0h exp 01", i, car);
      end
    end
    mem_wait = 1'b0;
    step();
    n++;
    checks++;
    if (car !== 8'h02) begin
      errors++;
      $display("FAIL stall_release got %0h exp 02", car);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n++;
    end
    checks++;
    if (car !== 8'h0C) begin
      errors++;
      $display("FAIL stall_add_wb got %0h exp 0c", car);
    end
    mem_wait = 1'b1;
    step();
    n++;
    checks++;
    if (car !== 8'h0C || instr_done !== 1'b0) begin
      errors++;
      $display("FAIL stall_end got car %0h done %b exp 0c 0",
               car, instr_done);
    end
    mem_wait = 1'b0;
    step();
    n++;
    checks++;
    if (car !== 8'h00 || instr_done !== 1'b1 || n != 11) begin
      errors++;
      $display("FAIL stall_finish got car %0h done %b len %0d exp 00 1 11",
               car, instr_done, n);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    opcode = 8'h09;
    for (int i = 0; i < 4; i++) step();
    step();
    checks++;
    if (car !== 8'h00 || illegal_op !== 1'b1 || instr_done !== 1'b0) begin
      errors++;
      $display("FAIL illegal_op got car %0h ill %b done %b exp 00 1 0",
               car, illegal_op, instr_done);
    end
    step();
    checks++;
    if (car !== 8'h01 || illegal_op !== 1'b0) begin
      errors++;
      $display("FAIL illegal_clear got car %0h ill %b exp 01 0",
               car, illegal_op);
    end
    zero_word = 1'b1;
    step();
    zero_word = 1'b0;
    checks++;
    if (car !== 8'h00 || illegal_op !== 1'b1 || instr_done !== 1'b0) begin
      errors++;
      $display("FAIL zero_word got car %0h ill %b done %b exp 00 1 0",
               car, illegal_op, instr_done);
    end
    step();
    checks++;
    if (car !== 8'h01 || illegal_op !== 1'b0 || instr_done !== 1'b0) begin
      errors++;
      $display("FAIL zero_clear got car %0h ill %b done %b exp 01 0 0",
               car, illegal_op, instr_done);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    opcode = 8'h08;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (car !== 8'h10) begin
      errors++;
      $display("FAIL mpy_ex got %0h exp 10", car);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (car !== 8'h00 || {halted, instr_done, illegal_op} !== 3'b000) begin
      errors++;
      $display("FAIL async_rst got car %0h flags %b exp 00 000",
               car, {halted, instr_done, illegal_op});
    end
    #1;
    rst = 1'b0;
    step();
    checks++;
    if (car !== 8'h01 || {instr_done, illegal_op} !== 2'b00) begin
      errors++;
      $display("FAIL after_rst got car %0h flags %b exp 01 00",
               car, {instr_done, illegal_op});
    end
  endtask

  initial begin
    rst = 1'b1;
    opcode = 8'h00;
    ind_bit = 1'b0;
    mem_wait = 1'b0;
    resume = 1'b0;
    zero_word = 1'b0;
    test_reset();
    test_add();
    test_sub_indirect();
    test_halt();
    test_stall();
    test_illegal();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
